// File: rtl/alarm_mode_controller.sv
// Alarm clock sequencer: five-state mode FSM, time-of-day and alarm registers,
// button arbitration (stop > mode > up > down), alarm trigger and ring auto-off.
module alarm_mode_controller #(
    parameter int unsigned RING_SECONDS = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       mode_p,
    input  logic       up_p,
    input  logic       down_p,
    input  logic       stop_p,
    output logic [2:0] mode,
    output logic [4:0] hours,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic [4:0] alm_hours,
    output logic [5:0] alm_minutes,
    output logic       alarm_en,
    output logic       ringing
);

    typedef enum logic [2:0] {
        RUN   = 3'd0,
        SET_H = 3'd1,
        SET_M = 3'd2,
        ALM_H = 3'd3,
        ALM_M = 3'd4
    } mode_e;

    localparam logic [7:0] RING_LIMIT = 8'(RING_SECONDS);

    mode_e      state_q, state_d;
    logic [4:0] hours_q, hours_d, alm_h_q, alm_h_d;
    logic [5:0] minutes_q, minutes_d, seconds_q, seconds_d, alm_m_q, alm_m_d;
    logic       alarm_en_q, alarm_en_d, ringing_q, ringing_d;
    logic [7:0] ring_cnt_q, ring_cnt_d;

    logic       any_p, do_mode, do_up, do_down, do_edit, clock_runs;
    logic [4:0] nx_h;
    logic [5:0] nx_m, nx_s;

    function automatic logic [4:0] step_h(input logic [4:0] v, input logic inc);
        if (inc) return (v == 5'd23) ? 5'd0 : v + 5'd1;
        return (v == 5'd0) ? 5'd23 : v - 5'd1;
    endfunction

    function automatic logic [5:0] step_m(input logic [5:0] v, input logic inc);
        if (inc) return (v == 6'd59) ? 6'd0 : v + 6'd1;
        return (v == 6'd0) ? 6'd59 : v - 6'd1;
    endfunction

    // Only the highest-priority pulse survives; lower ones are dropped this cycle.
    assign any_p   = stop_p | mode_p | up_p | down_p;
    assign do_mode = mode_p & ~stop_p;
    assign do_up   = up_p & ~stop_p & ~mode_p;
    assign do_down = down_p & ~stop_p & ~mode_p & ~up_p;
    assign do_edit = do_up | do_down;

    assign clock_runs = (state_q == RUN) || (state_q == ALM_H) || (state_q == ALM_M);

    always_comb begin
        nx_h = hours_q;
        nx_m = minutes_q;
        nx_s = seconds_q + 6'd1;
        if (seconds_q == 6'd59) begin
            nx_s = 6'd0;
            nx_m = minutes_q + 6'd1;
            if (minutes_q == 6'd59) begin
                nx_m = 6'd0;
                nx_h = (hours_q == 5'd23) ? 5'd0 : hours_q + 5'd1;
            end
        end
    end

    // NOTE: every next-state variable gets its hold value first so no path infers a latch.
    always_comb begin
        state_d    = state_q;
        hours_d    = hours_q;
        minutes_d  = minutes_q;
        seconds_d  = seconds_q;
        alm_h_d    = alm_h_q;
        alm_m_d    = alm_m_q;
        alarm_en_d = alarm_en_q;
        ringing_d  = ringing_q;
        ring_cnt_d = ring_cnt_q;

        if (tick_1hz && clock_runs) begin
            hours_d   = nx_h;
            minutes_d = nx_m;
            seconds_d = nx_s;
        end

        if (ringing_q) begin
            // Any accepted pulse is swallowed as a stop while sounding.
            if (any_p) begin
                ringing_d = 1'b0;
            end else if (tick_1hz) begin
                ring_cnt_d = ring_cnt_q + 8'd1;
                if (ring_cnt_q + 8'd1 == RING_LIMIT) ringing_d = 1'b0;
            end
        end else begin
            unique case (state_q)
                RUN: begin
                    if (stop_p) begin
                        alarm_en_d = ~alarm_en_q;
                    end else if (do_mode) begin
                        state_d   = SET_H;
                        seconds_d = 6'd0;
                    end
                end
                SET_H: begin
                    if (do_mode)      state_d = SET_M;
                    else if (do_edit) hours_d = step_h(hours_q, do_up);
                end
                SET_M: begin
                    if (do_mode)      state_d   = ALM_H;
                    else if (do_edit) minutes_d = step_m(minutes_q, do_up);
                end
                ALM_H: begin
                    if (do_mode)      state_d = ALM_M;
                    else if (do_edit) alm_h_d = step_h(alm_h_q, do_up);
                end
                ALM_M: begin
                    if (do_mode)      state_d = RUN;
                    else if (do_edit) alm_m_d = step_m(alm_m_q, do_up);
                end
                default: state_d = RUN;
            endcase

            if (state_q == RUN && tick_1hz && alarm_en_q && !do_mode &&
                nx_h == alm_h_q && nx_m == alm_m_q && nx_s == 6'd0) begin
                ringing_d  = 1'b1;
                ring_cnt_d = 8'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= RUN;
            hours_q    <= 5'd0;
            minutes_q  <= 6'd0;
            seconds_q  <= 6'd0;
            alm_h_q    <= 5'd0;
            alm_m_q    <= 6'd0;
            alarm_en_q <= 1'b0;
            ringing_q  <= 1'b0;
            ring_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            hours_q    <= hours_d;
            minutes_q  <= minutes_d;
            seconds_q  <= seconds_d;
            alm_h_q    <= alm_h_d;
            alm_m_q    <= alm_m_d;
            alarm_en_q <= alarm_en_d;
            ringing_q  <= ringing_d;
            ring_cnt_q <= ring_cnt_d;
        end
    end

    assign mode        = state_q;
    assign hours       = hours_q;
    assign minutes     = minutes_q;
    assign seconds     = seconds_q;
    assign alm_hours   = alm_h_q;
    assign alm_minutes = alm_m_q;
    assign alarm_en    = alarm_en_q;
    assign ringing     = ringing_q;

endmodule

// File: tb/tb_alarm_mode_controller.sv
// Scoreboard bench for alarm_mode_controller: stimulus pushes hand-computed
// output snapshots, a negedge monitor pops and compares them.
module tb_alarm_mode_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_1hz, mode_p, up_p, down_p, stop_p;
    logic [2:0] mode;
    logic [4:0] hours, alm_hours;
    logic [5:0] minutes, seconds, alm_minutes;
    logic       alarm_en, ringing;

    typedef struct packed {
        logic [2:0] md;
        logic [4:0] h;
        logic [5:0] m;
        logic [5:0] s;
        logic [4:0] ah;
        logic [5:0] am;
        logic       en;
        logic       ring;
    } snap_t;

    typedef struct {
        string name;
        snap_t exp;
    } entry_t;

    entry_t sb[$];
    int     total = 0;
    int     bad   = 0;
    snap_t  act;

    always #5 clk = ~clk;

    alarm_mode_controller #(.RING_SECONDS(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .tick_1hz   (tick_1hz),
        .mode_p     (mode_p),
        .up_p       (up_p),
        .down_p     (down_p),
        .stop_p     (stop_p),
        .mode       (mode),
        .hours      (hours),
        .minutes    (minutes),
        .seconds    (seconds),
        .alm_hours  (alm_hours),
        .alm_minutes(alm_minutes),
        .alarm_en   (alarm_en),
        .ringing    (ringing)
    );

    assign act = {mode, hours, minutes, seconds, alm_hours, alm_minutes, alarm_en, ringing};

    function automatic snap_t mk(input int md, h, m, s, ah, am, en, ring);
        snap_t r;
        r.md = 3'(md); r.h = 5'(h); r.m = 6'(m); r.s = 6'(s);
        r.ah = 5'(ah); r.am = 6'(am); r.en = 1'(en); r.ring = 1'(ring);
        return r;
    endfunction

    task automatic check(input string name, input snap_t got, input snap_t exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got mode=%0d %0d:%0d:%0d alm=%0d:%0d en=%0b ring=%0b, want mode=%0d %0d:%0d:%0d alm=%0d:%0d en=%0b ring=%0b",
                     name, got.md, got.h, got.m, got.s, got.ah, got.am, got.en, got.ring,
                     exp.md, exp.h, exp.m, exp.s, exp.ah, exp.am, exp.en, exp.ring);
        end
    endtask

    // Monitor: outputs are registered, so compare mid-cycle at the falling edge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            entry_t e;
            e = sb.pop_front();
            check(e.name, act, e.exp);
        end
    end

    task automatic push(input string name, input snap_t exp);
        entry_t e;
        e.name = name;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    task automatic cyc(input logic s, input logic m, input logic u, input logic d, input logic t);
        @(negedge clk);
        stop_p = s; mode_p = m; up_p = u; down_p = d; tick_1hz = t;
        @(posedge clk);
        #1;
        stop_p = 1'b0; mode_p = 1'b0; up_p = 1'b0; down_p = 1'b0; tick_1hz = 1'b0;
    endtask

    task automatic press_mode(input int n);
        for (int i = 0; i < n; i++) cyc(0, 1, 0, 0, 0);
    endtask

    task automatic press_up(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 1, 0, 0);
    endtask

    task automatic press_down(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 1, 0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 1);
    endtask

    initial begin
        rst = 1'b0;
        tick_1hz = 1'b0; mode_p = 1'b0; up_p = 1'b0; down_p = 1'b0; stop_p = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        push("reset", mk(0, 0, 0, 0, 0, 0, 0, 0));

        // Hours edit with wrap in both directions.
        press_mode(1);
        push("enter_set_h", mk(1, 0, 0, 0, 0, 0, 0, 0));
        press_up(24);
        push("hours_up24_wrap", mk(1, 0, 0, 0, 0, 0, 0, 0));
        press_up(1);
        push("hours_up25", mk(1, 1, 0, 0, 0, 0, 0, 0));
        press_down(2);
        push("hours_down_wrap", mk(1, 23, 0, 0, 0, 0, 0, 0));

        // Minutes edit, wrap, tick ignored in SET_M.
        press_mode(1);
        press_down(1);
        push("min_down_wrap", mk(2, 23, 59, 0, 0, 0, 0, 0));
        press_up(1);
        push("min_up_wrap", mk(2, 23, 0, 0, 0, 0, 0, 0));
        press_down(1);
        ticks(1);
        push("set_m_tick_ignored", mk(2, 23, 59, 0, 0, 0, 0, 0));

        // Back to RUN and roll over midnight.
        press_mode(3);
        push("back_to_run", mk(0, 23, 59, 0, 0, 0, 0, 0));
        ticks(59);
        push("time_235959", mk(0, 23, 59, 59, 0, 0, 0, 0));
        ticks(1);
        push("midnight_wrap", mk(0, 0, 0, 0, 0, 0, 0, 0));

        // 00:59:00 plus 60 ticks carries into the hour.
        press_mode(2);
        press_down(1);
        press_mode(3);
        ticks(60);
        push("hour_carry", mk(0, 1, 0, 0, 0, 0, 0, 0));

        // Time 00:01, alarm 00:02, arm, ring, auto-off after 3 ticks.
        press_mode(1);
        press_down(1);
        press_mode(1);
        press_up(1);
        press_mode(2);
        press_up(2);
        push("alarm_set", mk(4, 0, 1, 0, 0, 2, 0, 0));
        press_mode(1);
        ticks(58);
        cyc(1, 0, 0, 0, 0);
        push("arm_alarm", mk(0, 0, 1, 58, 0, 2, 1, 0));
        ticks(1);
        push("pre_ring", mk(0, 0, 1, 59, 0, 2, 1, 0));
        ticks(1);
        push("ring_rise", mk(0, 0, 2, 0, 0, 2, 1, 1));
        ticks(2);
        push("ring_held", mk(0, 0, 2, 2, 0, 2, 1, 1));
        ticks(1);
        push("ring_auto_off", mk(0, 0, 2, 3, 0, 2, 1, 0));

        // Re-arm for 00:03 and silence with mode_p.
        press_mode(4);
        press_up(1);
        press_mode(1);
        push("seconds_forced_zero", mk(0, 0, 2, 0, 0, 3, 1, 0));
        ticks(60);
        push("ring_rise2", mk(0, 0, 3, 0, 0, 3, 1, 1));
        cyc(0, 1, 0, 0, 0);
        push("mode_silences", mk(0, 0, 3, 0, 0, 3, 1, 0));
        cyc(1, 1, 1, 0, 0);
        push("stop_wins_arbitration", mk(0, 0, 3, 0, 0, 3, 0, 0));
        cyc(0, 0, 0, 1, 0);
        push("run_down_ignored", mk(0, 0, 3, 0, 0, 3, 0, 0));

        // ALM_M: tick and up in the same cycle both apply; stop ignored.
        press_mode(4);
        cyc(0, 0, 1, 0, 1);
        push("alm_tick_and_up", mk(4, 0, 3, 1, 0, 4, 0, 0));
        cyc(1, 0, 0, 0, 0);
        push("alm_stop_ignored", mk(4, 0, 3, 1, 0, 4, 0, 0));
        press_mode(1);

        // Ring at 00:04:00 then reset mid-ring with other inputs active.
        cyc(1, 0, 0, 0, 0);
        ticks(59);
        push("ring_rise3", mk(0, 0, 4, 0, 0, 4, 1, 1));
        @(negedge clk);
        rst = 1'b0; mode_p = 1'b1; tick_1hz = 1'b1; up_p = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b1; mode_p = 1'b0; tick_1hz = 1'b0; up_p = 1'b0;
        push("reset_mid_ring", mk(0, 0, 0, 0, 0, 0, 0, 0));

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending entries, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alarm_mode_controller.md
# alarm_mode_controller

Central sequencer for the alarm clock: consumes the one-cycle button pulses produced by the per-button rising-edge detectors, walks a five-state mode FSM, and owns the time-of-day and alarm registers. It keeps time from a 1 Hz enable and arbitrates simultaneous button pulses. It compares the running time against the alarm setting and drives the ringing output. Display and tone blocks read its registered outputs.

## Interface
- RING_SECONDS, 60: number of tick_1hz pulses after which ringing self-clears (range 1–255).
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-low reset.
- tick_1hz  in  1  one-cycle enable, once per second.
- mode_p  in  1  one-cycle pulse from the mode-button edge detector.
- up_p  in  1  one-cycle pulse, increment.
- down_p  in  1  one-cycle pulse, decrement.
- stop_p  in  1  one-cycle pulse, stop/alarm-enable toggle.
- mode  out  3  current state: RUN=0, SET_H=1, SET_M=2, ALM_H=3, ALM_M=4.
- hours  out  5  time hours, 0–23.
- minutes  out  6  time minutes, 0–59.
- seconds  out  6  time seconds, 0–59.
- alm_hours  out  5  alarm hours, 0–23.
- alm_minutes  out  6  alarm minutes, 0–59.
- alarm_en  out  1  alarm armed.
- ringing  out  1  alarm sounding.

## Operation
- Reset (rst=0 at a clk edge): mode=RUN, time 00:00:00, alarm 00:00, alarm_en=0, ringing=0, ring counter=0. Reset overrides every other input, including mid-edit and mid-ring.
- Button arbitration, per cycle: stop_p > mode_p > up_p > down_p. Only the highest-priority asserted pulse is acted on; the others in that cycle are discarded, not queued.
- While ringing=1, any accepted pulse clears ringing and is otherwise consumed. Mode, time and alarm are unchanged.
- mode_p cycles RUN→SET_H→SET_M→ALM_H→ALM_M→RUN.
- RUN: up_p and down_p are ignored. stop_p toggles alarm_en.
- SET_H / SET_M: up_p and down_p change hours (mod 24) or minutes (mod 60), with wrap-around. 23+1→0, 0−1→23, 59+1→0, 0−1→59.
  - seconds is forced to 0 on entry to SET_H and held there while in SET_H or SET_M.
  - tick_1hz is ignored in these states.
  - stop_p is ignored.
- ALM_H / ALM_M: up_p and down_p change alm_hours or alm_minutes with the same wrap rules. Time keeps running on tick_1hz. stop_p is ignored.
- Timekeeping in RUN, ALM_H and ALM_M: each tick_1hz advances seconds, carries into minutes, and carries into hours. 23:59:59 wraps to 00:00:00.
- Edit while the clock is running: if a tick and an accepted up_p/down_p on the alarm field fall in the same cycle, both take effect.
- Alarm trigger: only in state RUN, with alarm_en=1 and ringing=0. A tick_1hz whose next time equals alm_hours:alm_minutes:00 sets ringing=1 on that same edge. Entering a matching time through SET_H or SET_M never triggers.
- Auto-off: the ring counter clears when ringing sets and counts tick_1hz while ringing. When the counter reaches RING_SECONDS, ringing clears on that edge.
- Leaving RUN cannot occur while ringing, because the mode_p is consumed as a stop.

## Timing
- All outputs are registered. An accepted pulse sampled at edge k is visible on the outputs after edge k (1-cycle latency).
- The alarm match is evaluated combinationally on next-time, so ringing rises on the same edge the time reaches hh:mm:00.
- Auto-off: ringing falls on the edge of the RING_SECONDS-th tick_1hz after it rose.
- No back-pressure. Pulses are assumed to be one cycle wide. A pulse held high for n cycles acts n times.

## Test plan
- Reset then mode_p ×1, up_p ×25 → mode=1, hours=1 (wrap through 23→0). Then down_p ×2 → hours=23.
- Reach SET_M and set minutes=59. Return to RUN. Apply 60 ticks from 00:59:00 → time 01:00:00. Separately, force 23:59:59 and tick → 00:00:00.
- Set alarm 00:02 and alarm_en=1 (stop_p in RUN), time 00:01:58. Apply 2 ticks → ringing=1 at the edge of the second tick. With RING_SECONDS=3, 3 more ticks → ringing=0.
- While ringing, pulse mode_p → ringing=0 and mode stays RUN. Same cycle stop_p+mode_p+up_p in RUN (not ringing) → only alarm_en toggles, mode unchanged.
- In ALM_M, tick_1hz and up_p in the same cycle → seconds+1 and alm_minutes+1 both applied. In SET_M, a tick is ignored and seconds stays 0.
- rst=0 for one cycle while ringing=1 in ALM-edited state → all outputs at reset values on the next cycle.
